seg_display_driver: RTL

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed 7-segment driver: value digit plus overflow "E" digit,
// with a double-buffered shadow so updates only land on frame boundaries.
// Optional OVF_BLINK_EN: blink the "E" digit every BLINK_DIV frames.
module seg_display_driver #(
  parameter int REFRESH_DIV = 16,
  parameter int BLINK_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       ovf_in,
  input  logic       load,
  output logic [6:0] seg_out,
  output logic [1:0] an,
  output logic       pend
);
  localparam int             CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_E   = 7'b1001111;

  if (REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("seg_display_driver: REFRESH_DIV must be >= 2 and BLINK_DIV >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dsel_q, dsel_d;
  logic [6:0]    shd_seg_q, shd_seg_d, dsp_seg_q, dsp_seg_d, seg_q, seg_d;
  logic          shd_ovf_q, shd_ovf_d, dsp_ovf_q, dsp_ovf_d;
  logic          pend_q, pend_d;
  logic [1:0]    an_q, an_d;
  logic          tc, bnd, blank;

  assign tc  = (cnt_q == CNT_MAX);
  assign bnd = tc & dsel_q;

`ifdef OVF_BLINK_EN
  localparam int            BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (bnd) begin
      if (bcnt_q == BLK_MAX) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blank = blink_d;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d     = tc ? '0 : cnt_q + CW'(1);
    dsel_d    = tc ? ~dsel_q : dsel_q;
    shd_seg_d = shd_seg_q;
    shd_ovf_d = shd_ovf_q;
    dsp_seg_d = dsp_seg_q;
    dsp_ovf_d = dsp_ovf_q;
    pend_d    = pend_q;
    // Boundary promotes the old shadow before a same-cycle load overwrites it.
    if (bnd && pend_q) begin
      dsp_seg_d = shd_seg_q;
      dsp_ovf_d = shd_ovf_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      shd_seg_d = seg_in;
      shd_ovf_d = ovf_in;
      pend_d    = 1'b1;
    end
    // Outputs come from next state so they move only on toggle/load edges.
    an_d  = dsel_d ? 2'b10 : 2'b01;
    seg_d = dsp_seg_d;
    if (dsel_d)
      seg_d = (dsp_ovf_d && !blank) ? SEG_E : 7'b0000000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      dsel_q    <= 1'b0;
      shd_seg_q <= '0;
      shd_ovf_q <= 1'b0;
      dsp_seg_q <= '0;
      dsp_ovf_q <= 1'b0;
      pend_q    <= 1'b0;
      seg_q     <= '0;
      an_q      <= 2'b01;
    end else begin
      cnt_q     <= cnt_d;
      dsel_q    <= dsel_d;
      shd_seg_q <= shd_seg_d;
      shd_ovf_q <= shd_ovf_d;
      dsp_seg_q <= dsp_seg_d;
      dsp_ovf_q <= dsp_ovf_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an      = an_q;
  assign pend    = pend_q;
endmodule
